// File: rtl/otbn_rf_bignum_wr_arb.sv
// Write-port arbiter with a pending port-B queue for a single-write-port wide RF.
// Ports: wr_*_a/b in, rf_wr_* out, rd_addr/rf_rd_data/rd_data, stall, hazard, count, err. Macro: OTBN_RF_WR_ARB_FWD_EN.
module otbn_rf_bignum_wr_arb #(
  parameter int unsigned WdrAw   = 5,
  parameter int unsigned ExtWLEN = 312,
  parameter int unsigned Depth   = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [WdrAw-1:0]             wr_addr_a_i,
  input  logic [7:0]                   wr_en_a_i,
  input  logic [ExtWLEN-1:0]           wr_data_a_i,
  input  logic [WdrAw-1:0]             wr_addr_b_i,
  input  logic [7:0]                   wr_en_b_i,
  input  logic [ExtWLEN-1:0]           wr_data_b_i,
  output logic [WdrAw-1:0]             rf_wr_addr_o,
  output logic [7:0]                   rf_wr_en_o,
  output logic [ExtWLEN-1:0]           rf_wr_data_o,
  input  logic [WdrAw-1:0]             rd_addr_a_i,
  input  logic [ExtWLEN-1:0]           rf_rd_data_a_i,
  output logic [ExtWLEN-1:0]           rd_data_a_o,
  input  logic [WdrAw-1:0]             rd_addr_b_i,
  input  logic [ExtWLEN-1:0]           rf_rd_data_b_i,
  output logic [ExtWLEN-1:0]           rd_data_b_o,
  output logic                         stall_o,
  output logic                         rd_hazard_o,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic                         err_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned GW   = ExtWLEN / 8;

  logic [WdrAw-1:0]   q_addr   [Depth];
  logic [7:0]         q_en     [Depth];
  logic [ExtWLEN-1:0] q_data   [Depth];
  logic [WdrAw-1:0]   q_addr_d [Depth];
  logic [7:0]         q_en_d   [Depth];
  logic [ExtWLEN-1:0] q_data_d [Depth];
  logic [CntW-1:0]    cnt, cnt_d, wr_idx;
  logic               err_q;

  logic req_a, req_b, empty, full;
  logic pop, push, drop;

  assign req_a = |wr_en_a_i;
  assign req_b = |wr_en_b_i;
  assign empty = (cnt == '0);
  assign full  = (cnt == CntW'(Depth));

  assign pop  = !req_a && !empty;
  assign drop = req_a && req_b && full;
  assign push = req_b && (req_a || !empty) && !drop;

  assign stall_o = full;
  assign count_o = cnt;
  assign err_o   = err_q;

  always_comb begin
    rf_wr_addr_o = wr_addr_a_i;
    rf_wr_en_o   = '0;
    rf_wr_data_o = wr_data_a_i;
    if (req_a) begin
      rf_wr_en_o = wr_en_a_i;
    end else if (!empty) begin
      // A fully killed head still pops, issuing no enables.
      rf_wr_addr_o = q_addr[0];
      rf_wr_en_o   = q_en[0];
      rf_wr_data_o = q_data[0];
    end else if (req_b) begin
      rf_wr_addr_o = wr_addr_b_i;
      rf_wr_en_o   = wr_en_b_i;
      rf_wr_data_o = wr_data_b_i;
    end
  end

  // Slot 0 is the head; slots below cnt are valid.
  always_comb begin
    q_addr_d = q_addr;
    q_en_d   = q_en;
    q_data_d = q_data;
    wr_idx   = cnt - CntW'(pop);
    cnt_d    = cnt - CntW'(pop) + CntW'(push);
    // Older entries lose granules that A overwrites now.
    if (req_a) begin
      for (int i = 0; i < Depth; i++) begin
        if (CntW'(i) < cnt && q_addr[i] == wr_addr_a_i) begin
          q_en_d[i] = q_en[i] & ~wr_en_a_i;
        end
      end
    end
    if (pop) begin
      for (int i = 0; i + 1 < Depth; i++) begin
        q_addr_d[i] = q_addr[i+1];
        q_en_d[i]   = q_en[i+1];
        q_data_d[i] = q_data[i+1];
      end
    end
    if (push) begin
      for (int i = 0; i < Depth; i++) begin
        if (CntW'(i) == wr_idx) begin
          q_addr_d[i] = wr_addr_b_i;
          q_en_d[i]   = wr_en_b_i;
          q_data_d[i] = wr_data_b_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt   <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        q_addr[i] <= '0;
        q_en[i]   <= '0;
        q_data[i] <= '0;
      end
    end else begin
      cnt   <= cnt_d;
      err_q <= drop;
      q_addr <= q_addr_d;
      q_en   <= q_en_d;
      q_data <= q_data_d;
    end
  end

`ifdef OTBN_RF_WR_ARB_FWD_EN
  // Newest matching entry wins per granule; index order is age order.
  always_comb begin
    rd_data_a_o = rf_rd_data_a_i;
    rd_data_b_o = rf_rd_data_b_i;
    for (int g = 0; g < 8; g++) begin
      for (int i = 0; i < Depth; i++) begin
        if (CntW'(i) < cnt && q_en[i][g]) begin
          if (q_addr[i] == rd_addr_a_i) begin
            rd_data_a_o[g*GW +: GW] = q_data[i][g*GW +: GW];
          end
          if (q_addr[i] == rd_addr_b_i) begin
            rd_data_b_o[g*GW +: GW] = q_data[i][g*GW +: GW];
          end
        end
      end
    end
  end

  assign rd_hazard_o = 1'b0;
`else
  assign rd_data_a_o = rf_rd_data_a_i;
  assign rd_data_b_o = rf_rd_data_b_i;

  always_comb begin
    rd_hazard_o = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (CntW'(i) < cnt && |q_en[i] &&
          (q_addr[i] == rd_addr_a_i || q_addr[i] == rd_addr_b_i)) begin
        rd_hazard_o = 1'b1;
      end
    end
  end
`endif

endmodule
